// File: rtl/life_pkg.sv
// Shared types and constants for the bonus-life pickup and the player life counter.
package life_pkg;

  localparam logic [10:0] OFFSCREEN_POS = 11'h7FF;

  typedef logic [3:0] lives_t;

  typedef enum logic {
    WATCH,
    ACK
  } pickup_st_t;

  typedef enum logic [1:0] {
    PLAY,
    INVULN,
    OVER
  } life_st_t;

  function automatic lives_t sat_inc(input lives_t v, input lives_t ceil);
    return (v >= ceil) ? ceil : v + 4'd1;
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box intersection; boxes that only share an edge do not overlap.
module aabb_overlap #(
  parameter int A_W = 24,
  parameter int A_H = 24,
  parameter int B_W = 32,
  parameter int B_H = 48
) (
  input  logic [10:0] i_a_x,
  input  logic [10:0] i_a_y,
  input  logic [10:0] i_b_x,
  input  logic [10:0] i_b_y,
  output logic        o_overlap
);

  // One extra bit so that position + size near the right/bottom edge cannot wrap.
  logic [11:0] w_ax, w_ay, w_bx, w_by;

  assign w_ax = {1'b0, i_a_x};
  assign w_ay = {1'b0, i_a_y};
  assign w_bx = {1'b0, i_b_x};
  assign w_by = {1'b0, i_b_y};

  assign o_overlap = (w_ax < w_bx + 12'(B_W)) &&
                     (w_bx < w_ax + 12'(A_W)) &&
                     (w_ay < w_by + 12'(B_H)) &&
                     (w_by < w_ay + 12'(A_H));

endmodule

// File: rtl/life_collect.sv
// Bonus-life pickup handshake and player life/invulnerability/game-over tracking.
// Optional blink of the player during invulnerability: define LIFE_COLLECT_BLINK_EN.
module life_collect
  import life_pkg::*;
#(
  parameter int LIFE_W        = 24,
  parameter int LIFE_H        = 24,
  parameter int PLAYER_W      = 32,
  parameter int PLAYER_H      = 48,
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 5,
  parameter int INVULN_FRAMES = 60,
  parameter int ACK_TIMEOUT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] lifeTopLeftX,
  input  logic [10:0] lifeTopLeftY,
  input  logic [10:0] playerTopLeftX,
  input  logic [10:0] playerTopLeftY,
  input  logic        playerHit,
  input  logic        restart,
  output logic        crash,
  output logic        lifeGained,
  output logic [3:0]  lives,
  output logic        invulnerable,
  output logic        gameOver,
  output logic        playerVisible
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  logic w_present, w_box_hit, w_pickup, w_hit;

  pickup_st_t       r_pk_st, w_pk_nxt;
  logic [ACK_W-1:0] r_ack_cnt, w_ack_cnt_nxt;
  life_st_t         r_life_st, w_life_nxt;
  lives_t           r_lives, w_lives_nxt, w_lives_inc;
  logic [INV_W-1:0] r_inv_cnt, w_inv_cnt_nxt;
  logic             r_life_gained;

  aabb_overlap #(
    .A_W(LIFE_W),   .A_H(LIFE_H),
    .B_W(PLAYER_W), .B_H(PLAYER_H)
  ) u_overlap (
    .i_a_x    (lifeTopLeftX),
    .i_a_y    (lifeTopLeftY),
    .i_b_x    (playerTopLeftX),
    .i_b_y    (playerTopLeftY),
    .o_overlap(w_box_hit)
  );

  assign w_present = (lifeTopLeftX != OFFSCREEN_POS);
  assign w_pickup  = (r_pk_st == WATCH) && startOfFrame && w_present && w_box_hit &&
                     (r_life_st != OVER);
  assign w_hit     = playerHit && (r_life_st == PLAY);

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pk_st       <= WATCH;
      r_ack_cnt     <= '0;
      r_life_st     <= PLAY;
      r_lives       <= lives_t'(INIT_LIVES);
      r_inv_cnt     <= '0;
      r_life_gained <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values, independent of statement order.
      r_pk_st       <= w_pk_nxt;
      r_ack_cnt     <= w_ack_cnt_nxt;
      r_life_st     <= w_life_nxt;
      r_lives       <= w_lives_nxt;
      r_inv_cnt     <= w_inv_cnt_nxt;
      r_life_gained <= w_pickup;
    end
  end

  // Pickup next state: hold the acknowledge until the object leaves or the timeout expires
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    w_pk_nxt      = r_pk_st;
    w_ack_cnt_nxt = r_ack_cnt;
    unique case (r_pk_st)
      WATCH: begin
        if (w_pickup) begin
          w_pk_nxt      = ACK;
          w_ack_cnt_nxt = '0;
        end
      end
      ACK: begin
        if (!w_present || (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1))) begin
          w_pk_nxt      = WATCH;
          w_ack_cnt_nxt = '0;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + 1'b1;
        end
      end
      default: w_pk_nxt = WATCH;
    endcase
  end

  // Life next state: credit the pickup first, then apply the hit to the credited count
  assign w_lives_inc = w_pickup ? sat_inc(r_lives, lives_t'(MAX_LIVES)) : r_lives;

  always_comb begin
    w_life_nxt    = r_life_st;
    w_lives_nxt   = w_lives_inc;
    w_inv_cnt_nxt = r_inv_cnt;
    if (restart) begin
      w_life_nxt    = PLAY;
      w_lives_nxt   = lives_t'(INIT_LIVES);
      w_inv_cnt_nxt = '0;
    end else begin
      unique case (r_life_st)
        PLAY: begin
          if (w_hit) begin
            if (w_lives_inc > 4'd1) begin
              w_lives_nxt   = w_lives_inc - 4'd1;
              w_life_nxt    = INVULN;
              w_inv_cnt_nxt = INV_W'(INVULN_FRAMES);
            end else begin
              w_lives_nxt = '0;
              w_life_nxt  = OVER;
            end
          end
        end
        INVULN: begin
          if (startOfFrame) begin
            if (r_inv_cnt <= INV_W'(1)) begin
              w_life_nxt    = PLAY;
              w_inv_cnt_nxt = '0;
            end else begin
              w_inv_cnt_nxt = r_inv_cnt - 1'b1;
            end
          end
        end
        OVER:    w_lives_nxt = r_lives;
        default: w_life_nxt  = PLAY;
      endcase
    end
  end

  // Outputs decode registered state only
  always_comb begin
    crash        = (r_pk_st == ACK);
    lifeGained   = r_life_gained;
    lives        = r_lives;
    invulnerable = (r_life_st == INVULN);
    gameOver     = (r_life_st == OVER);
  end

`ifdef LIFE_COLLECT_BLINK_EN
  logic [1:0] r_blink_cnt;
  logic       r_visible;

  // Low for the first four frames of immunity, then toggling every four frames
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else if (w_life_nxt != INVULN) begin
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else if (r_life_st != INVULN) begin
      r_blink_cnt <= '0;
      r_visible   <= 1'b0;
    end else if (startOfFrame) begin
      r_blink_cnt <= r_blink_cnt + 2'd1;
      if (r_blink_cnt == 2'd3) r_visible <= ~r_visible;
    end
  end

  assign playerVisible = r_visible;
`else
  assign playerVisible = 1'b1;
`endif

endmodule

// File: tb/tb_life_collect.sv
// Directed bench for life_collect: overlap vector table plus pickup, hit, game-over and reset sequences.
module tb_life_collect;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, playerHit, restart;
  logic [10:0] lifeTopLeftX, lifeTopLeftY, playerTopLeftX, playerTopLeftY;
  logic        crash, lifeGained, invulnerable, gameOver, playerVisible;
  logic [3:0]  lives;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  life_collect dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .lifeTopLeftX  (lifeTopLeftX),
    .lifeTopLeftY  (lifeTopLeftY),
    .playerTopLeftX(playerTopLeftX),
    .playerTopLeftY(playerTopLeftY),
    .playerHit     (playerHit),
    .restart       (restart),
    .crash         (crash),
    .lifeGained    (lifeGained),
    .lives         (lives),
    .invulnerable  (invulnerable),
    .gameOver      (gameOver),
    .playerVisible (playerVisible)
  );

  typedef struct {
    string       name;
    logic [10:0] lx, ly, px, py;
    logic        exp_pick;
  } ovl_vec_t;

  ovl_vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Credit one pickup and clear the object so the acknowledge ends promptly
  task automatic pickup();
    lifeTopLeftX = 11'd100;
    lifeTopLeftY = 11'd400;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    lifeTopLeftX = 11'h7FF;
    tick();
    tick();
  endtask

  task automatic hit();
    playerHit = 1'b1;
    tick();
    playerHit = 1'b0;
  endtask

  initial begin
    int n_crash, n_gain;

    vecs[0]  = '{"inside",        11'd100,  11'd400, 11'd90,   11'd380, 1'b1};
    vecs[1]  = '{"right_touch",   11'd122,  11'd400, 11'd90,   11'd380, 1'b0};
    vecs[2]  = '{"right_in",      11'd121,  11'd400, 11'd90,   11'd380, 1'b1};
    vecs[3]  = '{"left_touch",    11'd66,   11'd400, 11'd90,   11'd380, 1'b0};
    vecs[4]  = '{"left_in",       11'd67,   11'd400, 11'd90,   11'd380, 1'b1};
    vecs[5]  = '{"bottom_touch",  11'd100,  11'd428, 11'd90,   11'd380, 1'b0};
    vecs[6]  = '{"bottom_in",     11'd100,  11'd427, 11'd90,   11'd380, 1'b1};
    vecs[7]  = '{"top_touch",     11'd100,  11'd356, 11'd90,   11'd380, 1'b0};
    vecs[8]  = '{"top_in",        11'd100,  11'd357, 11'd90,   11'd380, 1'b1};
    vecs[9]  = '{"absent",        11'h7FF,  11'd400, 11'd2040, 11'd380, 1'b0};
    vecs[10] = '{"edge_nowrap",   11'd2040, 11'd400, 11'd2030, 11'd380, 1'b1};
    vecs[11] = '{"far_apart",     11'd10,   11'd400, 11'd2040, 11'd380, 1'b0};

    reset = 1'b1; startOfFrame = 1'b0; playerHit = 1'b0; restart = 1'b0;
    lifeTopLeftX = 11'h7FF; lifeTopLeftY = 11'd0;
    playerTopLeftX = 11'd90; playerTopLeftY = 11'd380;
    tick();
    tick();
    check("rst_lives", lives, 3);
    check("rst_crash", crash, 0);
    check("rst_gained", lifeGained, 0);
    check("rst_invuln", invulnerable, 0);
    check("rst_over", gameOver, 0);
    check("rst_visible", playerVisible, 1);
    reset = 1'b0;

    // Overlap table, observed through the pickup handshake
    foreach (vecs[i]) begin
      do_reset();
      playerTopLeftX = vecs[i].px; playerTopLeftY = vecs[i].py;
      lifeTopLeftX   = vecs[i].lx; lifeTopLeftY   = vecs[i].ly;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check({"ovl_crash_", vecs[i].name}, crash, int'(vecs[i].exp_pick));
      check({"ovl_lives_", vecs[i].name}, lives, vecs[i].exp_pick ? 4 : 3);
      lifeTopLeftX = 11'h7FF;
      tick();
      tick();
    end
    playerTopLeftX = 11'd90; playerTopLeftY = 11'd380;

    // Pickup with object cleared two clocks later
    do_reset();
    lifeTopLeftX = 11'd100; lifeTopLeftY = 11'd400;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t1_crash_on", crash, 1);
    check("t1_gained", lifeGained, 1);
    check("t1_lives", lives, 4);
    tick();
    check("t1_crash_hold", crash, 1);
    check("t1_gained_pulse", lifeGained, 0);
    lifeTopLeftX = 11'h7FF;
    tick();
    check("t1_crash_off", crash, 0);

    // Saturation at MAX_LIVES, frames during ACK ignored, acknowledge timeout
    pickup();
    check("t3_lives5", lives, 5);
    lifeTopLeftX = 11'd100; lifeTopLeftY = 11'd400;
    n_crash = 0; n_gain = 0;
    startOfFrame = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 2) startOfFrame = 1'b0;
      if (c == 5) lifeTopLeftX = 11'h7FF;
      n_crash += int'(crash);
      n_gain  += int'(lifeGained);
    end
    check("t3_crash_clocks", n_crash, 4);
    check("t3_gain_count", n_gain, 1);
    check("t3_lives_sat", lives, 5);

    // Pickup and hit together at MAX_LIVES
    lifeTopLeftX = 11'd100;
    startOfFrame = 1'b1; playerHit = 1'b1;
    tick();
    startOfFrame = 1'b0; playerHit = 1'b0; lifeTopLeftX = 11'h7FF;
    check("max_pick_hit_lives", lives, 4);
    check("max_pick_hit_inv", invulnerable, 1);

    // Hit, 60 frames of immunity, ignored second hit, blink pattern
    do_reset();
    hit();
    check("t4_lives", lives, 2);
    for (int k = 0; k < 60; k++) begin
      check("t4_invuln", invulnerable, 1);
`ifdef LIFE_COLLECT_BLINK_EN
      check("t4_blink", playerVisible, (k / 4) % 2);
`else
      check("t4_visible", playerVisible, 1);
`endif
      if (k == 10) begin
        hit();
        check("t4_hit_ignored", lives, 2);
      end
      frame();
    end
    check("t4_invuln_end", invulnerable, 0);
    check("t4_visible_end", playerVisible, 1);
    check("t4_lives_end", lives, 2);

    // Down to one life, simultaneous pickup+hit, game over, restart
    hit();
    run_frames(60);
    check("t5_lives1", lives, 1);
    check("t5_play", invulnerable, 0);
    lifeTopLeftX = 11'd100;
    startOfFrame = 1'b1; playerHit = 1'b1;
    tick();
    startOfFrame = 1'b0; playerHit = 1'b0; lifeTopLeftX = 11'h7FF;
    check("t5_both_lives", lives, 1);
    check("t5_both_inv", invulnerable, 1);
    check("t5_both_notover", gameOver, 0);
    tick();
    run_frames(60);
    hit();
    check("t5_over_lives", lives, 0);
    check("t5_over", gameOver, 1);
    check("t5_over_notinv", invulnerable, 0);
    lifeTopLeftX = 11'd100;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t5_over_nocrash", crash, 0);
    check("t5_over_nogain", lifeGained, 0);
    hit();
    check("t5_over_lives_held", lives, 0);
    lifeTopLeftX = 11'h7FF;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("t5_restart_lives", lives, 3);
    check("t5_restart_over", gameOver, 0);

    // Restart with a pickup: lives reload, handshake still runs
    lifeTopLeftX = 11'd100;
    startOfFrame = 1'b1; restart = 1'b1;
    tick();
    startOfFrame = 1'b0; restart = 1'b0; lifeTopLeftX = 11'h7FF;
    check("rs_pick_lives", lives, 3);
    check("rs_pick_crash", crash, 1);
    check("rs_pick_gain", lifeGained, 1);
    tick();

    // Reset while both in ACK and INVULN
    do_reset();
    hit();
    lifeTopLeftX = 11'd100;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("t6_pre_crash", crash, 1);
    check("t6_pre_inv", invulnerable, 1);
    check("t6_pre_lives", lives, 3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_crash", crash, 0);
    check("t6_lives", lives, 3);
    check("t6_invuln", invulnerable, 0);
    check("t6_gained", lifeGained, 0);
    check("t6_visible", playerVisible, 1);
    lifeTopLeftX = 11'h7FF;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
